// File: rtl/fp_writeback_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_writeback_scheduler_if
// Description : Bundle of the writeback request bus, decode issue port,
//               flush, register-file write port and error flag of the FP
//               writeback scheduler.
//               master : requesters / decode / flush source (drives inputs)
//               slave  : the scheduler (drives grants, stall, RF port, error)
//   req_valid/req_ready/req_rd/req_data/req_64bit : per-unit writeback reqs
//   iss_*                                        : decode issue + hazard stall
//   flush                                        : clear all busy bits
//   rf_*                                         : register-file write port
//   err_misaligned                               : sticky odd-rd double flag
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_writeback_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [5*NUM_REQ-1:0]  req_rd;
    logic [64*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_64bit;

    logic                  iss_valid;
    logic [4:0]            iss_rd;
    logic                  iss_64bit;
    logic [4:0]            iss_ra;
    logic [4:0]            iss_rb;
    logic                  iss_a64;
    logic                  iss_b64;
    logic                  iss_stall;

    logic                  flush;

    logic                  rf_writeEnable;
    logic [4:0]            rf_rd;
    logic [63:0]           rf_busW;
    logic                  rf_64bit;
    logic                  err_misaligned;

    modport master (
        output req_valid, req_rd, req_data, req_64bit,
        output iss_valid, iss_rd, iss_64bit, iss_ra, iss_rb, iss_a64, iss_b64,
        output flush,
        input  req_ready, iss_stall,
        input  rf_writeEnable, rf_rd, rf_busW, rf_64bit, err_misaligned
    );

    modport slave (
        input  req_valid, req_rd, req_data, req_64bit,
        input  iss_valid, iss_rd, iss_64bit, iss_ra, iss_rb, iss_a64, iss_b64,
        input  flush,
        output req_ready, iss_stall,
        output rf_writeEnable, rf_rd, rf_busW, rf_64bit, err_misaligned
    );
endinterface
`default_nettype wire

// File: rtl/fp_writeback_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_writeback_scheduler
// Description : Owns the single write port of the 32 x 32-bit FP register
//               file. Round-robin arbitrates NUM_REQ writeback requesters,
//               registers the winner onto the RF port one cycle later, and
//               keeps a per-register busy scoreboard that stalls decode on
//               RAW/WAW hazards.
// Ports       : clk   - clock, all state on rising edge
//               reset - asynchronous, active-low
//               bus   - fp_writeback_scheduler_if.slave (requests, issue,
//                       flush, RF write port, sticky misalignment error)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_writeback_scheduler #(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    fp_writeback_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registers touched by an access: a double covers the aligned even/odd
    // pair regardless of the low bit of r.
    function automatic logic [31:0] reg_mask(input logic [4:0] r, input logic dbl);
        logic [31:0] m;
        m = 32'd0;
        if (dbl) begin
            m[{r[4:1], 1'b0}] = 1'b1;
            m[{r[4:1], 1'b1}] = 1'b1;
        end else begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

    logic [4:0]  req_rd_arr   [NUM_REQ];
    logic [63:0] req_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_rd_arr[g]   = bus.req_rd[5*g +: 5];
        assign req_data_arr[g] = bus.req_data[64*g +: 64];
    end

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]      busy_q, busy_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [63:0]      rf_busw_q, rf_busw_d;
    logic             rf_64_q, rf_64_d;
    logic             err_q, err_d;

    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [NUM_REQ-1:0] ready;
    int               scan_idx;
    logic [4:0]       grant_rd;
    logic             grant_64;
    logic             iss_stall;
    logic             iss_accept;

    // Round-robin: scan upward from rr_ptr, wrapping; first valid wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_valid && bus.req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_valid) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign grant_rd = req_rd_arr[grant_idx];
    assign grant_64 = bus.req_64bit[grant_idx];

    // Hazard check looks only at the registered scoreboard: a consumer of a
    // result issues no earlier than the cycle after the RF write.
    assign iss_stall  = bus.iss_valid &
                        (|(busy_q & (reg_mask(bus.iss_ra, bus.iss_a64) |
                                     reg_mask(bus.iss_rb, bus.iss_b64) |
                                     reg_mask(bus.iss_rd, bus.iss_64bit))));
    assign iss_accept = bus.iss_valid & ~iss_stall & ~bus.flush;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_we_d   = grant_valid;
        rf_rd_d   = rf_rd_q;
        rf_busw_d = rf_busw_q;
        rf_64_d   = rf_64_q;
        err_d     = err_q;
        busy_d    = busy_q;

        if (grant_valid) begin
            rr_ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            rf_rd_d   = grant_64 ? {grant_rd[4:1], 1'b0} : grant_rd;
            rf_busw_d = req_data_arr[grant_idx];
            rf_64_d   = grant_64;
            if (grant_64 && grant_rd[0]) begin
                err_d = 1'b1;
            end
        end

        if (iss_accept && bus.iss_64bit && bus.iss_rd[0]) begin
            err_d = 1'b1;
        end

        // Clear and set never overlap on one register (the WAW stall
        // prevents it), so applying clear first then set is safe.
        if (rf_we_q) begin
            busy_d = busy_d & ~reg_mask(rf_rd_q, rf_64_q);
        end
        if (iss_accept) begin
            busy_d = busy_d | reg_mask(bus.iss_rd, bus.iss_64bit);
        end
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            busy_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_busw_q <= '0;
            rf_64_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_busw_q <= rf_busw_d;
            rf_64_q   <= rf_64_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready      = ready;
    assign bus.iss_stall      = iss_stall;
    assign bus.rf_writeEnable = rf_we_q;
    assign bus.rf_rd          = rf_rd_q;
    assign bus.rf_busW        = rf_busw_q;
    assign bus.rf_64bit       = rf_64_q;
    assign bus.err_misaligned = err_q;

endmodule
`default_nettype wire
